// File: rtl/ofs_fim_eth_pause_ctrl.sv
// ============================================================================
// ofs_fim_eth_pause_ctrl
//
// Multi-channel flow-control sideband generator sitting between the AFU /
// HE-HSSI and the Ethernet MAC pause/PFC inputs. Per-channel level requests
// are turned into MAC-compliant signals:
//   - link pause: one-cycle XOFF pulses, periodic XOFF refresh while held,
//     an XON pulse on release, with a minimum spacing between pulses;
//   - PFC: per-priority XOFF levels with release hysteresis.
// Each channel also keeps a saturating count of XOFF pulses it has issued.
//
// Ports:
//   i_clk        single clock for the whole block
//   i_rst        synchronous reset, active-high
//   i_enable     [NUM_CH]           per-channel flow-control enable
//   i_req_xoff   [NUM_CH]           link-pause request level
//   i_req_pfc    [NUM_CH*NUM_PRIO]  PFC request levels, ch c at [c*NUM_PRIO +: NUM_PRIO]
//   i_cnt_clr    synchronous clear of all statistics counters
//   o_pause_xoff [NUM_CH]           XOFF pulse to MAC
//   o_pause_xon  [NUM_CH]           XON pulse to MAC
//   o_pfc_xoff   [NUM_CH*NUM_PRIO]  PFC XOFF levels to MAC, same packing as i_req_pfc
//   o_xoff_cnt   [NUM_CH*CNT_W]     XOFF pulses issued, ch c at [c*CNT_W +: CNT_W]
// ============================================================================
module ofs_fim_eth_pause_ctrl #(
    parameter int NUM_CH         = 4,
    parameter int NUM_PRIO       = 8,
    parameter int REFRESH_CYCLES = 1024,
    parameter int MIN_GAP        = 16,
    parameter int PFC_HOLD       = 64,
    parameter int CNT_W          = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_CH-1:0]            i_enable,
    input  logic [NUM_CH-1:0]            i_req_xoff,
    input  logic [NUM_CH*NUM_PRIO-1:0]   i_req_pfc,
    input  logic                         i_cnt_clr,
    output logic [NUM_CH-1:0]            o_pause_xoff,
    output logic [NUM_CH-1:0]            o_pause_xon,
    output logic [NUM_CH*NUM_PRIO-1:0]   o_pfc_xoff,
    output logic [NUM_CH*CNT_W-1:0]      o_xoff_cnt
);

    localparam int TMR_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int GAP_W  = $clog2(MIN_GAP + 1);
    localparam int HOLD_W = (PFC_HOLD > 0) ? $clog2(PFC_HOLD + 1) : 1;

    localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(REFRESH_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);
    localparam logic [GAP_W-1:0]  GAP_SAT    = GAP_W'(MIN_GAP);
    localparam logic [GAP_W-1:0]  GAP_OK     = GAP_W'(MIN_GAP - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE    = GAP_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(PFC_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_XON_PEND = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Link pause: one independent FSM + timers per channel
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t           r_state;
        state_t           w_next_state;
        logic [TMR_W-1:0] r_timer;
        logic [GAP_W-1:0] r_gap;
        logic             r_xoff;
        logic             r_xon;
        logic [CNT_W-1:0] r_cnt;
        logic             w_want;
        logic             w_gap_ok;
        logic             w_fire_xoff;
        logic             w_fire_xon;

        assign w_want   = i_enable[c] & i_req_xoff[c];
        // Pulse i at edge t clears the counter; it reaches MIN_GAP-1 at edge
        // t+MIN_GAP-1, so the next pulse lands MIN_GAP cycles later.
        assign w_gap_ok = (r_gap >= GAP_OK);

        // State register.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_state <= ST_IDLE;
            end else begin
                r_state <= w_next_state;
            end
        end

        // Next-state logic. A release always passes through XON_PEND, so the
        // XON is at least one cycle after the drop and a quick re-assert
        // cancels it without disturbing the refresh schedule.
        always_comb begin
            w_next_state = r_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_want && w_gap_ok) begin
                        w_next_state = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!w_want) begin
                        w_next_state = ST_XON_PEND;
                    end
                end
                ST_XON_PEND: begin
                    if (w_want) begin
                        w_next_state = ST_HOLD;
                    end else if (w_gap_ok) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end

        // Pulse decisions for the current state; these get registered below.
        always_comb begin
            w_fire_xoff = 1'b0;
            w_fire_xon  = 1'b0;
            case (r_state)
                ST_IDLE:     w_fire_xoff = w_want & w_gap_ok;
                ST_HOLD:     w_fire_xoff = w_want & (r_timer == '0) & w_gap_ok;
                ST_XON_PEND: w_fire_xon  = ~w_want & w_gap_ok;
                default:     ;
            endcase
        end

        // Registered pulses, refresh timer, gap counter and XOFF statistics.
        // The timer free-runs down between reloads so HOLD/XON_PEND bounces
        // keep the original refresh cadence.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_xoff  <= 1'b0;
                r_xon   <= 1'b0;
                r_timer <= '0;
                r_gap   <= GAP_SAT;
                r_cnt   <= '0;
            end else begin
                r_xoff <= w_fire_xoff;
                r_xon  <= w_fire_xon;

                if (w_fire_xoff) begin
                    r_timer <= TMR_RELOAD;
                end else if (r_timer != '0) begin
                    r_timer <= r_timer - TMR_ONE;
                end

                if (w_fire_xoff || w_fire_xon) begin
                    r_gap <= '0;
                end else if (r_gap != GAP_SAT) begin
                    r_gap <= r_gap + GAP_ONE;
                end

                if (i_cnt_clr) begin
                    r_cnt <= '0;
                end else if (w_fire_xoff && (r_cnt != CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end

        assign o_pause_xoff[c]              = r_xoff;
        assign o_pause_xon[c]               = r_xon;
        assign o_xoff_cnt[c*CNT_W +: CNT_W] = r_cnt;
    end

    // ------------------------------------------------------------------------
    // PFC: per-priority level with release hysteresis
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_pfc_ch
        for (genvar p = 0; p < NUM_PRIO; p++) begin : g_pfc_prio
            localparam int IDX = c * NUM_PRIO + p;

            logic [HOLD_W-1:0] r_hold;
            logic [HOLD_W-1:0] w_hold_next;
            logic              r_req_d;
            logic              r_pfc;

            // Disable wipes the hold; otherwise a falling request arms it.
            always_comb begin
                w_hold_next = r_hold;
                if (!i_enable[c]) begin
                    w_hold_next = '0;
                end else if (r_req_d && !i_req_pfc[IDX]) begin
                    w_hold_next = HOLD_LOAD;
                end else if (r_hold != '0) begin
                    w_hold_next = r_hold - HOLD_ONE;
                end
            end

            // The output uses the next hold value so the fall cycle itself
            // stays high and the level has no gap at the request edge.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_hold  <= '0;
                    r_req_d <= 1'b0;
                    r_pfc   <= 1'b0;
                end else begin
                    r_hold  <= w_hold_next;
                    r_req_d <= i_req_pfc[IDX];
                    r_pfc   <= i_enable[c] & (i_req_pfc[IDX] | (w_hold_next != '0));
                end
            end

            assign o_pfc_xoff[IDX] = r_pfc;
        end
    end

endmodule

// File: tb/tb_ofs_fim_eth_pause_ctrl.sv
// ============================================================================
// tb_ofs_fim_eth_pause_ctrl
//
// Self-checking bench for ofs_fim_eth_pause_ctrl with 2 channels, refresh of
// 32 cycles, a 4-cycle pulse gap, PFC hold of 8 and 4-bit counters. A
// timestamp-based model predicts every output each cycle; directed scenarios
// additionally pin cycle-exact literal expectations.
// ============================================================================
module tb_ofs_fim_eth_pause_ctrl;

    localparam int NC       = 2;
    localparam int NP       = 8;
    localparam int REFRESH  = 32;
    localparam int GAP      = 4;
    localparam int PHOLD    = 8;
    localparam int CW       = 4;
    localparam int CNT_SAT  = 15;
    localparam int LOGLEN   = 720;

    logic               clk;
    logic               tbRst;
    logic [NC-1:0]      tbEnable;
    logic [NC-1:0]      tbReqXoff;
    logic [NC*NP-1:0]   tbReqPfc;
    logic               tbCntClr;
    logic [NC-1:0]      dutXoff;
    logic [NC-1:0]      dutXon;
    logic [NC*NP-1:0]   dutPfc;
    logic [NC*CW-1:0]   dutCnt;

    int checkCount = 0;
    int passCount  = 0;

    ofs_fim_eth_pause_ctrl #(
        .NUM_CH         (NC),
        .NUM_PRIO       (NP),
        .REFRESH_CYCLES (REFRESH),
        .MIN_GAP        (GAP),
        .PFC_HOLD       (PHOLD),
        .CNT_W          (CW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (tbRst),
        .i_enable     (tbEnable),
        .i_req_xoff   (tbReqXoff),
        .i_req_pfc    (tbReqPfc),
        .i_cnt_clr    (tbCntClr),
        .o_pause_xoff (dutXoff),
        .o_pause_xon  (dutXon),
        .o_pfc_xoff   (dutPfc),
        .o_xoff_cnt   (dutCnt)
    );

    // Free-running clock; inputs change and outputs are sampled on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared comparison helper: counts every check, reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model. Link pause is described with timestamps: when the
    // last pulse was issued, when the refresh schedule was anchored, whether
    // the MAC is currently paused, and whether the request was held last
    // cycle (a release/re-assert costs one cycle of observation before any
    // XON or refresh). PFC remembers the cycle of the last qualified fall.
    // ------------------------------------------------------------------------
    int          n = 0;
    bit          modelReady = 0;
    bit          mPaused   [NC];
    bit          mPrevWant [NC];
    int          mLastPulse[NC];
    int          mAnchor   [NC];
    int          mCnt      [NC];
    bit          mPrevReq  [NC*NP];
    bit          mFallValid[NC*NP];
    int          mFall     [NC*NP];
    logic [NC-1:0]    expXoff;
    logic [NC-1:0]    expXon;
    logic [NC*NP-1:0] expPfc;
    logic [NC*CW-1:0] expCnt;

    // Model update at each active edge, from the inputs the DUT also samples.
    always @(posedge clk) begin
        if (tbRst) begin
            for (int c = 0; c < NC; c++) begin
                mPaused[c]    = 0;
                mPrevWant[c]  = 0;
                mLastPulse[c] = -1000;
                mAnchor[c]    = -1000;
                mCnt[c]       = 0;
            end
            for (int i = 0; i < NC*NP; i++) begin
                mPrevReq[i]   = 0;
                mFallValid[i] = 0;
                mFall[i]      = 0;
            end
            expXoff    = '0;
            expXon     = '0;
            expPfc     = '0;
            expCnt     = '0;
            modelReady = 1;
        end else begin
            for (int c = 0; c < NC; c++) begin
                bit want, gapOk, xo, xn;
                want  = tbEnable[c] && tbReqXoff[c];
                gapOk = (n - mLastPulse[c]) >= GAP;
                xo = 0;
                xn = 0;
                if (!mPaused[c]) begin
                    xo = want && gapOk;
                end else if (want && mPrevWant[c]) begin
                    xo = ((n - mAnchor[c]) >= REFRESH) && gapOk;
                end else if (!want && !mPrevWant[c]) begin
                    xn = gapOk;
                end
                if (xo) begin
                    mPaused[c]    = 1;
                    mAnchor[c]    = n;
                    mLastPulse[c] = n;
                end
                if (xn) begin
                    mPaused[c]    = 0;
                    mLastPulse[c] = n;
                end
                mPrevWant[c] = want;
                if (tbCntClr) mCnt[c] = 0;
                else if (xo && mCnt[c] < CNT_SAT) mCnt[c] = mCnt[c] + 1;
                expXoff[c]           = xo;
                expXon[c]            = xn;
                expCnt[c*CW +: CW]   = mCnt[c][CW-1:0];
            end
            for (int i = 0; i < NC*NP; i++) begin
                bit r, e;
                r = tbReqPfc[i];
                e = tbEnable[i / NP];
                if (!e) mFallValid[i] = 0;
                else if (mPrevReq[i] && !r) begin
                    mFall[i]      = n;
                    mFallValid[i] = 1;
                end
                expPfc[i]   = e && (r || (mFallValid[i] && (n - mFall[i]) < PHOLD));
                mPrevReq[i] = r;
            end
        end
        n++;
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("pause_xoff", 32'(dutXoff), 32'(expXoff));
            checkOutput("pause_xon",  32'(dutXon),  32'(expXon));
            checkOutput("pfc_xoff",   32'(dutPfc),  32'(expPfc));
            checkOutput("xoff_cnt",   32'(dutCnt),  32'(expCnt));
            checkOutput("xoff_xon_exclusive", 32'(dutXoff & dutXon), 32'd0);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus and per-scenario observation logs (index = cycle number).
    // ------------------------------------------------------------------------
    bit [LOGLEN-1:0] obsXoff0;
    bit [LOGLEN-1:0] obsXon0;
    bit [LOGLEN-1:0] obsXoff1;
    bit [LOGLEN-1:0] obsXon1;
    bit [LOGLEN-1:0] obsPfc11;
    logic [CW-1:0]   obsCnt0 [LOGLEN];

    // Drive one cycle of inputs, then step to the next negedge.
    task automatic applyStimulus(input logic [NC-1:0] en, input logic [NC-1:0] reqX,
                                 input logic [NC*NP-1:0] reqP, input logic clr, input logic rstIn);
        tbEnable  = en;
        tbReqXoff = reqX;
        tbReqPfc  = reqP;
        tbCntClr  = clr;
        tbRst     = rstIn;
        @(negedge clk);
    endtask

    function automatic int countRange(input bit [LOGLEN-1:0] v, input int lo, input int hi);
        int k = 0;
        for (int i = lo; i <= hi; i++) if (v[i]) k++;
        return k;
    endfunction

    // Reset, then run one directed scenario, logging outputs per cycle.
    task automatic runScenario(input int id, input int len);
        logic [NC-1:0]    en;
        logic [NC-1:0]    rx;
        logic [NC*NP-1:0] rp;
        logic             clr;
        logic             rs;
        applyStimulus('0, '0, '0, 1'b0, 1'b1);
        applyStimulus('0, '0, '0, 1'b0, 1'b1);
        obsXoff0 = '0; obsXon0 = '0; obsXoff1 = '0; obsXon1 = '0; obsPfc11 = '0;
        for (int i = 0; i < LOGLEN; i++) obsCnt0[i] = '0;
        for (int t = 0; t < len; t++) begin
            en = 2'b11; rx = '0; rp = '0; clr = 1'b0; rs = 1'b0;
            case (id)
                2: rx[0] = (t >= 10 && t < 110);
                3: rx[0] = (t == 10);
                4: rx[0] = (t >= 10 && t != 20 && t < 60);
                5: begin
                    en       = (t < 38) ? 2'b11 : 2'b01;
                    rp[11]   = (t >= 10 && t < 15) || (t >= 30 && t < 35);
                end
                6: begin
                    rx[0] = (t >= 10 && t < 662);
                    clr   = (t == 650);
                    rs    = (t == 660 || t == 661);
                end
                default: ;
            endcase
            applyStimulus(en, rx, rp, clr, rs);
            obsXoff0[t+1] = dutXoff[0];
            obsXon0[t+1]  = dutXon[0];
            obsXoff1[t+1] = dutXoff[1];
            obsXon1[t+1]  = dutXon[1];
            obsPfc11[t+1] = dutPfc[11];
            obsCnt0[t+1]  = dutCnt[CW-1:0];
        end
    endtask

    initial begin
        tbRst = 1'b1; tbEnable = '0; tbReqXoff = '0; tbReqPfc = '0; tbCntClr = 1'b0;

        // Idle after reset: nothing may come out.
        runScenario(1, 20);
        checkOutput("s1_xoff_idle", 32'(dutXoff), 32'd0);
        checkOutput("s1_xon_idle",  32'(dutXon),  32'd0);
        checkOutput("s1_pfc_idle",  32'(dutPfc),  32'd0);
        checkOutput("s1_cnt_idle",  32'(dutCnt),  32'd0);

        // Held request: XOFF at 11 then every 32 cycles; release seen at
        // edge 110 parks in XON_PEND, XON follows in cycle 112.
        runScenario(2, 130);
        checkOutput("s2_xoff_11",  32'(obsXoff0[11]),  32'd1);
        checkOutput("s2_xoff_43",  32'(obsXoff0[43]),  32'd1);
        checkOutput("s2_xoff_75",  32'(obsXoff0[75]),  32'd1);
        checkOutput("s2_xoff_107", 32'(obsXoff0[107]), 32'd1);
        checkOutput("s2_xoff_total", 32'(countRange(obsXoff0, 0, 130)), 32'd4);
        checkOutput("s2_xon_112",  32'(obsXon0[112]),  32'd1);
        checkOutput("s2_xon_total", 32'(countRange(obsXon0, 0, 130)), 32'd1);
        checkOutput("s2_cnt",      32'(obsCnt0[130]),  32'd4);
        checkOutput("s2_ch1_quiet", 32'(countRange(obsXoff1, 0, 130) + countRange(obsXon1, 0, 130)), 32'd0);

        // One-cycle request: XON held off until the gap is satisfied.
        runScenario(3, 30);
        checkOutput("s3_xoff_11", 32'(obsXoff0[11]), 32'd1);
        checkOutput("s3_xon_15",  32'(obsXon0[15]),  32'd1);
        checkOutput("s3_xon_14",  32'(obsXon0[14]),  32'd0);
        checkOutput("s3_xoff_total", 32'(countRange(obsXoff0, 0, 30)), 32'd1);

        // One-cycle drop inside the hold: no XON, refresh still at 43.
        runScenario(4, 80);
        checkOutput("s4_xoff_total", 32'(countRange(obsXoff0, 0, 62)), 32'd2);
        checkOutput("s4_refresh_43", 32'(obsXoff0[43]), 32'd1);
        checkOutput("s4_no_early_xon", 32'(countRange(obsXon0, 0, 61)), 32'd0);
        checkOutput("s4_xon_62", 32'(obsXon0[62]), 32'd1);

        // PFC hysteresis on ch1/p3 and disable during hold.
        runScenario(5, 50);
        checkOutput("s5_pfc_10", 32'(obsPfc11[10]), 32'd0);
        checkOutput("s5_pfc_11", 32'(obsPfc11[11]), 32'd1);
        checkOutput("s5_pfc_23", 32'(obsPfc11[23]), 32'd1);
        checkOutput("s5_pfc_24", 32'(obsPfc11[24]), 32'd0);
        checkOutput("s5_pfc_width", 32'(countRange(obsPfc11, 0, 28)), 32'd13);
        checkOutput("s5_pfc_38", 32'(obsPfc11[38]), 32'd1);
        checkOutput("s5_pfc_disable_39", 32'(obsPfc11[39]), 32'd0);

        // Counter saturation, clear on a pulse cycle, reset while holding.
        runScenario(6, 700);
        checkOutput("s6_pulses_20", 32'(countRange(obsXoff0, 0, 640)), 32'd20);
        checkOutput("s6_cnt_sat",   32'(obsCnt0[640]), 32'd15);
        checkOutput("s6_xoff_651",  32'(obsXoff0[651]), 32'd1);
        checkOutput("s6_clr_wins",  32'(obsCnt0[651]), 32'd0);
        checkOutput("s6_no_xon_after_rst", 32'(countRange(obsXon0, 640, 700)), 32'd0);
        checkOutput("s6_no_xoff_after_rst", 32'(countRange(obsXoff0, 661, 700)), 32'd0);
        checkOutput("s6_cnt_after_rst", 32'(obsCnt0[700]), 32'd0);

        applyStimulus('0, '0, '0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ofs_fim_eth_pause_ctrl.md
Name: ofs_fim_eth_pause_ctrl

Overview:
Multi-channel flow-control sideband generator between the AFU/HE-HSSI and the Ethernet MAC pause/PFC inputs. It converts per-channel level requests into MAC-compliant signals:
- link pause: one-cycle XOFF pulses, periodic XOFF refresh, XON on release, with minimum pulse spacing;
- PFC: per-priority XOFF levels with release hysteresis.

It generalises the single-channel pause_xoff/pause_xon/pfc_xoff[7:0] sideband to N channels × P priorities, and adds saturating XOFF statistics per channel.

Parameters:
- NUM_CH, 4, Ethernet channels (matches NUM_ETH_CHANNELS of the build).
- NUM_PRIO, 8, PFC priorities per channel.
- REFRESH_CYCLES, 1024, cycles between consecutive XOFF pulses while a request is held. Must be ≥ MIN_GAP.
- MIN_GAP, 16, minimum cycles from one pulse to the next pulse (either kind) on a channel. Must be ≥ 2.
- PFC_HOLD, 64, cycles pfc_xoff stays high after its request drops. 0 = no hysteresis.
- CNT_W, 16, width of each XOFF statistics counter.

Ports:
- clk, in, 1: single clock for the whole block.
- rst, in, 1: synchronous reset, active-high.
- enable, in, NUM_CH: per-channel flow-control enable (CSR).
- req_xoff, in, NUM_CH: link-pause request level.
- req_pfc, in, NUM_CH*NUM_PRIO: PFC request levels; channel c occupies bits [c*NUM_PRIO +: NUM_PRIO].
- cnt_clr, in, 1: synchronous clear of all statistics counters.
- pause_xoff, out, NUM_CH: XOFF pulse to MAC (avalon_st_pause_data[1]).
- pause_xon, out, NUM_CH: XON pulse to MAC (avalon_st_pause_data[0]).
- pfc_xoff, out, NUM_CH*NUM_PRIO: PFC XOFF levels to MAC; same packing as req_pfc.
- xoff_cnt, out, NUM_CH*CNT_W: XOFF pulses issued per channel; channel c occupies [c*CNT_W +: CNT_W].

Behaviour:
- Reset: all outputs 0; every channel FSM in IDLE; refresh timers and hold timers 0; gap counters at MIN_GAP (gap satisfied). Reset mid-operation aborts silently: no XON is emitted.
- All outputs are registered. A decision made from inputs sampled at edge t appears on the outputs after edge t (one-cycle latency).
- Per-channel gap counter:
  - cleared to 0 on any pulse, then increments, saturating at MIN_GAP;
  - gap_ok = (gap_cnt ≥ MIN_GAP-1);
  - consequently rising edges of successive pulses are ≥ MIN_GAP cycles apart.
- pause_xoff and pause_xon are never high together on a channel. Each pulse is exactly one cycle wide.
- Channel FSM, state IDLE:
  - if enable & req_xoff & gap_ok: pulse XOFF, load refresh timer with REFRESH_CYCLES-1, go to HOLD;
  - otherwise stay in IDLE (the XOFF is deferred until gap_ok).
- Channel FSM, state HOLD:
  - if !req_xoff | !enable: go to XON_PEND;
  - else if timer == 0 & gap_ok: pulse XOFF (refresh), reload timer;
  - else decrement timer, saturating at 0.
- Channel FSM, state XON_PEND:
  - if enable & req_xoff: return to HOLD with no pulse; the timer keeps running;
  - else if gap_ok: pulse XON, go to IDLE;
  - the timer keeps decrementing while in XON_PEND.
- PFC, per channel c and priority p:
  - hold_cnt loads PFC_HOLD on the cycle req falls (registered previous req = 1, current = 0), otherwise decrements to 0;
  - pfc_xoff = enable[c] & (req | hold_cnt ≠ 0);
  - enable[c] low clears all of that channel's hold counters immediately, so outputs are 0 the next cycle;
  - req re-rising during hold keeps the output high continuously, with no glitch.
- Statistics:
  - xoff_cnt[c] increments on every XOFF pulse (initial and refresh) and saturates at 2^CNT_W-1;
  - cnt_clr has priority over a simultaneous increment, giving 0.
- Channels are fully independent; no shared arbitration.

Test Plan:
All scenarios use NUM_CH=2, REFRESH_CYCLES=32, MIN_GAP=4, PFC_HOLD=8, CNT_W=4.
- Reset, then idle 20 cycles → all outputs 0, xoff_cnt=0.
- ch0 enable=1; req_xoff high at cycle 10, held 100 cycles → XOFF at 11, 43, 75, 107; XON 1 cycle after the drop; xoff_cnt[0]=4; ch1 outputs stay 0.
- req_xoff high 1 cycle at t=10 → XOFF at 11, XON at 15 (gap enforced); never both high in one cycle.
- req_xoff drops at t=20 and re-rises at t=21 (inside the gap) → no XON, no extra XOFF; next refresh stays on the original 32-cycle schedule.
- req_pfc[ch1,p3] high for 5 cycles → pfc_xoff[ch1,p3] high 1 cycle later, falls 8 cycles after the request drops. Dropping enable[1] mid-hold → output 0 the next cycle.
- 20 XOFF pulses on ch0 → xoff_cnt[0] saturates at 15. Assert cnt_clr in the same cycle as an XOFF pulse → counter 0. Assert rst while in HOLD → no XON, all outputs 0.
